// File: rtl/axi4_lite_queued_master_if.sv
// axi4_lite_queued_master_if: AXI4-Lite bus bundle between the queued master and its slave
interface axi4_lite_queued_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]              M_AXI_ARPROT;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;
  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );
  modport slave (
    input M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_queued_master.sv
// axi4_lite_queued_master: in-order AXI4-Lite master fed by a command FIFO, one transaction at a time
module axi4_lite_queued_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_VAL = 255
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  axi4_lite_queued_master_if.master m_axi
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int OW = PW + 1;
  localparam int CW = (TIMEOUT_VAL < 2) ? 1 : $clog2(TIMEOUT_VAL + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_VAL);
  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         wstrb;
  } cmd_t;
  typedef enum logic [1:0] {IDLE, ADDR, RESP, HOLD} state_t;
  cmd_t                  mem_q [CMD_DEPTH];
  cmd_t                  cur_q, cur_d;
  state_t                state_q, state_d;
  logic [PW-1:0]         wr_q, rd_q;
  logic [OW-1:0]         occ_q;
  logic                  live_q, push, pop, expired, tmo;
  logic                  aw_q, aw_d, w_q, w_d, ar_q, ar_d, b_q, b_d, r_q, r_d;
  logic                  rv_q, rv_d, to_q, to_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [CW-1:0]         tcnt_q, tcnt_d;
  // live_q holds cmd_ready low until the first edge after reset release
  assign cmd_ready = live_q && (occ_q != OW'(CMD_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign expired   = (TIMEOUT_VAL != 0) && (tcnt_q == TMAX);
  always_ff @(posedge M_AXI_ACLK)
    if (push) mem_q[wr_q] <= {cmd_write, cmd_addr, cmd_wdata, cmd_wstrb};
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      live_q <= 1'b0;
    end else begin
      wr_q   <= wr_q + PW'(push);
      rd_q   <= rd_q + PW'(pop);
      occ_q  <= occ_q + OW'(push) - OW'(pop);
      live_q <= 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    aw_d    = aw_q;
    w_d     = w_q;
    ar_d    = ar_q;
    b_d     = b_q;
    r_d     = r_q;
    rv_d    = rv_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    tcnt_d  = (tcnt_q == TMAX) ? tcnt_q : tcnt_q + CW'(1);
    pop     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: if (occ_q != '0) begin
        pop     = 1'b1;
        cur_d   = mem_q[rd_q];
        aw_d    = mem_q[rd_q].write;
        w_d     = mem_q[rd_q].write;
        ar_d    = !mem_q[rd_q].write;
        tcnt_d  = '0;
        state_d = ADDR;
      end
      ADDR: if (!(aw_q || w_q || ar_q)) begin
        b_d     = cur_q.write;
        r_d     = !cur_q.write;
        tcnt_d  = '0;
        state_d = RESP;
      end else begin
        aw_d = aw_q && !m_axi.M_AXI_AWREADY;
        w_d  = w_q && !m_axi.M_AXI_WREADY;
        ar_d = ar_q && !m_axi.M_AXI_ARREADY;
        tmo  = expired && ({aw_d, w_d, ar_d} == {aw_q, w_q, ar_q});
      end
      RESP: if ((b_q && m_axi.M_AXI_BVALID) || (r_q && m_axi.M_AXI_RVALID)) begin
        b_d     = 1'b0;
        r_d     = 1'b0;
        rv_d    = 1'b1;
        to_d    = 1'b0;
        resp_d  = cur_q.write ? m_axi.M_AXI_BRESP : m_axi.M_AXI_RRESP;
        rdata_d = cur_q.write ? '0 : m_axi.M_AXI_RDATA;
        state_d = HOLD;
      end else tmo = expired;
      default: if (rsp_ready) begin
        rv_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (tmo) begin
      {aw_d, w_d, ar_d, b_d, r_d} = '0;
      rv_d    = 1'b1;
      to_d    = 1'b1;
      resp_d  = 2'b10;
      rdata_d = '0;
      state_d = HOLD;
    end
  end
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q <= IDLE;
      cur_q   <= '0;
      {aw_q, w_q, ar_q, b_q, r_q, rv_q, to_q} <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      {aw_q, w_q, ar_q, b_q, r_q, rv_q, to_q} <= {aw_d, w_d, ar_d, b_d, r_d, rv_d, to_d};
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      tcnt_q  <= tcnt_d;
    end
  end
  assign m_axi.M_AXI_AWADDR  = cur_q.addr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = aw_q;
  assign m_axi.M_AXI_WDATA   = cur_q.wdata;
  assign m_axi.M_AXI_WSTRB   = cur_q.wstrb;
  assign m_axi.M_AXI_WVALID  = w_q;
  assign m_axi.M_AXI_BREADY  = b_q;
  assign m_axi.M_AXI_ARADDR  = cur_q.addr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = ar_q;
  assign m_axi.M_AXI_RREADY  = r_q;
  assign rsp_valid   = rv_q;
  assign rsp_write   = cur_q.write;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = to_q;
endmodule

// File: tb/tb_axi4_lite_queued_master.sv
// tb_axi4_lite_queued_master: directed checks of the queued AXI4-Lite master against a latency-programmable slave
module tb_axi4_lite_queued_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TV = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  int n_vec = 0, n_err = 0;
  int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
  int aw_age = 0, w_age = 0, ar_age = 0, b_age = 0, r_age = 0, ar_hs = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [AW-1:0] aw_cap = '0, ar_cap = '0;
  logic [DW-1:0] w_cap = '0;
  logic [3:0] ws_cap = '0;
  axi4_lite_queued_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();
  axi4_lite_queued_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(4), .TIMEOUT_VAL(TV)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi(axi)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rd_model(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("push_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("rsp_wait", rsp_valid, 1);
  endtask
  task automatic get_rsp(output logic w, output logic [31:0] d, output logic [1:0] r, output logic t);
    wait_rsp();
    w = rsp_write;
    d = rsp_rdata;
    r = rsp_resp;
    t = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  // slave decides each ready/valid at the falling edge from the age of the request it sees
  initial begin
    {axi.M_AXI_AWREADY, axi.M_AXI_WREADY, axi.M_AXI_ARREADY, axi.M_AXI_BVALID, axi.M_AXI_RVALID} = '0;
    axi.M_AXI_BRESP = '0;
    axi.M_AXI_RRESP = '0;
    axi.M_AXI_RDATA = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {axi.M_AXI_AWREADY, axi.M_AXI_WREADY, axi.M_AXI_ARREADY, axi.M_AXI_BVALID, axi.M_AXI_RVALID} = '0;
        {aw_age, w_age, ar_age, b_age, r_age} = '0;
      end else begin
        axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && aw_age == aw_lat;
        if (axi.M_AXI_AWREADY) aw_cap = axi.M_AXI_AWADDR;
        aw_age = axi.M_AXI_AWVALID ? aw_age + 1 : 0;
        axi.M_AXI_WREADY = axi.M_AXI_WVALID && w_age == w_lat;
        if (axi.M_AXI_WREADY) {w_cap, ws_cap} = {axi.M_AXI_WDATA, axi.M_AXI_WSTRB};
        w_age = axi.M_AXI_WVALID ? w_age + 1 : 0;
        axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && ar_age == ar_lat;
        if (axi.M_AXI_ARREADY) begin
          ar_cap = axi.M_AXI_ARADDR;
          ar_hs++;
        end
        ar_age = axi.M_AXI_ARVALID ? ar_age + 1 : 0;
        axi.M_AXI_BVALID = axi.M_AXI_BREADY && b_age == b_lat;
        axi.M_AXI_BRESP  = b_resp_cfg;
        b_age = axi.M_AXI_BREADY ? b_age + 1 : 0;
        axi.M_AXI_RVALID = axi.M_AXI_RREADY && r_age == r_lat;
        axi.M_AXI_RRESP  = r_resp_cfg;
        axi.M_AXI_RDATA  = axi.M_AXI_RVALID ? rd_model(ar_cap) : '0;
        r_age = axi.M_AXI_RREADY ? r_age + 1 : 0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic w, t;
    logic [31:0] d, snap;
    logic [1:0] r;
    int hi, bad, hs0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, 0);
    chk("rst_axi", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID, axi.M_AXI_BREADY, axi.M_AXI_RREADY}, 0);
    rst = 1'b0;
    #1 chk("ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", cmd_ready, 1);
    aw_lat = 1; w_lat = 3; b_lat = 0; b_resp_cfg = 2'b00;
    push(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("issue_lat_c1", axi.M_AXI_AWVALID, 0);
    @(negedge clk);
    chk("issue_lat_c2", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID}, 2'b11);
    get_rsp(w, d, r, t);
    chk("wr_rsp", {w, t, r}, {1'b1, 1'b0, 2'b00});
    chk("wr_bus", {aw_cap, w_cap, ws_cap}, {32'h10, 32'hDEADBEEF, 4'hF});
    ar_lat = 0; r_lat = 1; r_resp_cfg = 2'b00;
    push(1'b0, 32'h100, '0, '0);
    wait_rsp();
    snap = rsp_rdata;
    hs0 = ar_hs;
    for (int i = 0; i < 4; i++) push(1'b0, 32'h200 + 32'(i * 4), '0, '0);
    chk("fifo_full", cmd_ready, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== snap || rsp_resp !== 2'b00 || axi.M_AXI_ARVALID !== 1'b0) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("no_issue_in_hold", ar_hs - hs0, 0);
    get_rsp(w, d, r, t);
    chk("rd_first", {w, t, r, d}, {1'b0, 1'b0, 2'b00, rd_model(32'h100)});
    for (int i = 0; i < 4; i++) begin
      get_rsp(w, d, r, t);
      chk("rd_order", {w, t, r, d}, {1'b0, 1'b0, 2'b00, rd_model(32'h200 + 32'(i * 4))});
    end
    ar_lat = 1000;
    push(1'b0, 32'h40, '0, '0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (axi.M_AXI_ARVALID) hi++;
      else if (hi > 0) break;
    end
    chk("to_arvalid_cycles", hi, TV + 1);
    get_rsp(w, d, r, t);
    chk("to_rsp", {w, t, r, d}, {1'b0, 1'b1, 2'b10, 32'h0});
    ar_lat = TV; r_lat = 0; r_resp_cfg = 2'b01;
    push(1'b0, 32'h44, '0, '0);
    get_rsp(w, d, r, t);
    chk("hs_beats_timeout", {w, t, r, d}, {1'b0, 1'b0, 2'b01, rd_model(32'h44)});
    aw_lat = 0; w_lat = 0; b_lat = 1000;
    push(1'b1, 32'h48, 32'h55, 4'h1);
    get_rsp(w, d, r, t);
    chk("b_timeout_rsp", {w, t, r, d}, {1'b1, 1'b1, 2'b10, 32'h0});
    chk("b_timeout_bready", axi.M_AXI_BREADY, 0);
    b_lat = 0; w_lat = 1000;
    push(1'b1, 32'h80, 32'hCAFEF00D, 4'hC);
    hi = 0;
    while (!axi.M_AXI_WVALID && hi < 10) begin
      @(negedge clk);
      hi++;
    end
    chk("rst_pre_wvalid", axi.M_AXI_WVALID, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_wvalid", {axi.M_AXI_WVALID, axi.M_AXI_AWVALID}, 2'b00);
    chk("rst_async_ready", {cmd_ready, rsp_valid}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w_lat = 2; b_resp_cfg = 2'b10;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || axi.M_AXI_WVALID || axi.M_AXI_AWVALID) bad++;
    end
    chk("rst_discard", bad, 0);
    push(1'b1, 32'h84, 32'h12345678, 4'h3);
    get_rsp(w, d, r, t);
    chk("fresh_wr_rsp", {w, t, r}, {1'b1, 1'b0, 2'b10});
    chk("fresh_wr_bus", {aw_cap, w_cap, ws_cap}, {32'h84, 32'h12345678, 4'h3});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
